spi_mem_arbiter: RTL
====================

# spi_mem_arbiter

Sequencer and arbiter for the single external SPI RAM shared by instruction fetch and data-memory accesses. It accepts one 16-bit instruction-fetch port and one 8-bit load/store port and grants the SPI bus to one at a time, with data priority. For each grant it runs a complete mode-0 SPI transaction: command, 16-bit address, payload. It sits between the CPU core (program counter, load/store path) and the uio SPI pads.

## Interface
Parameters: none. The SCK ratio is fixed at clk/2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- fetch_req  in  1  fetch request, level; held with fetch_addr until fetch_ready.
- fetch_addr  in  16  byte address of the instruction's high byte.
- fetch_data  out  16  fetched instruction; {byte@addr, byte@addr+1}.
- fetch_ready  out  1  one-cycle pulse; fetch_data valid from this cycle.
- data_req  in  1  data request, level; held with data_we/addr/wdata until data_ready.
- data_we  in  1  1 = write, 0 = read.
- data_addr  in  16  data byte address.
- data_wdata  in  8  write byte.
- data_rdata  out  8  read byte.
- data_ready  out  1  one-cycle pulse on read or write completion.
- busy  out  1  high whenever the state is not IDLE.
- spi_cs  out  1  chip select, active-low.
- spi_sck  out  1  serial clock, mode 0 (idle low).
- spi_mosi  out  1  serial out, MSB first.
- spi_miso  in  1  serial in, connected directly to the pad.

## Operation
- States: IDLE, SELECT, SHIFT, DONE.
- **IDLE**
  - If data_req=1, grant data; otherwise, if fetch_req=1, grant fetch.
  - Data always wins a simultaneous request.
  - Latch the granted command, address and wdata into a shift register, then go to SELECT.
- **Frames** (N = bit count)
  - Fetch: 0x03, addr[15:8], addr[7:0], then 16 read bits. N = 40.
  - Data read: 0x03, addr, then 8 read bits. N = 32.
  - Data write: 0x02, addr, wdata. N = 32.
- **SELECT**: spi_cs=0, spi_sck=0, spi_mosi = frame bit 0. Lasts 1 cycle, then go to SHIFT.
- **SHIFT**
  - Bit counter runs 0..N-1. Each bit takes 2 cycles: sck high, then sck low.
  - spi_miso is sampled on the edge ending the high phase.
  - mosi advances to the next bit on that same edge.
  - mosi = 0 during read payload bits.
  - After bit N-1, go to DONE.
- **DONE**
  - spi_cs=1, spi_sck=0.
  - The granted port's ready pulses and its read data is updated. Write completion updates no data.
  - Next state is IDLE.
- Only the granted port ever sees ready.
- A requester that drops req mid-transaction does not abort it. The transaction completes and ready still pulses.
- Read data outputs hold their value until the next completed read on the same port.
- No wrap handling: only the start address is sent. Fetch at 0xFFFF reads its second byte from 0x0000 via the device's sequential mode.
- Fixed priority is intentional: the core issues at most one data access per instruction, so fetch cannot starve.

## Timing
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, fetch_ready=0, data_ready=0, fetch_data=0, data_rdata=0, busy=0, state IDLE.
- rst asserted mid-transaction: the next edge forces reset values, no ready is issued, and the partial frame is abandoned.
- Request sampled in IDLE at cycle T:
  - SELECT at T+1.
  - SHIFT at T+2 .. T+2N+1.
  - DONE (ready high) at T+2N+2.
  - IDLE at T+2N+3.
- Resulting latency: fetch ready at T+82; data ready at T+66.
- spi_cs is high for at least 1 cycle between frames: the DONE cycle.
- A new request can be accepted at T+2N+3. Back-to-back frame start (SELECT) is therefore at T+2N+4.
- spi_sck is high in cycles T+2+2k and low in T+3+2k, for k = 0..N-1.
- busy rises at T+1 and falls at T+2N+3.

## Test plan
- **Fetch.** Reset, then fetch_req with addr 0x1234; RAM model returns 0xA5,0x3C.
  - MOSI carries 0x03,0x12,0x34.
  - fetch_ready pulses at T+82 with fetch_data = 0xA53C. cs low for exactly 81 cycles.
- **Write then read.** Write 0x5A to 0x00FF, then read 0x00FF.
  - Write: MOSI carries 0x02,0x00,0xFF,0x5A; data_ready at T+66.
  - Read: data_rdata = 0x5A.
- **Simultaneous requests.** fetch_req and data_req rise together.
  - Data frame first, then fetch frame starting 2 cycles after data_ready. No fetch_ready during the data frame.
- **Reset mid-frame.** rst at bit 20 of a fetch.
  - Next cycle: cs=1, sck=0, busy=0. No ready pulse. A subsequent fetch completes correctly.
- **Wrap.** Fetch at 0xFFFF; model holds 0x11 at 0xFFFF and 0x22 at 0x0000.
  - Address bytes sent are 0xFF,0xFF. fetch_data = 0x1122.
- **Dropped request.** data_req dropped after 5 cycles.
  - The frame completes with all 32 bits and data_ready pulses once.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: data-priority arbiter that sequences mode-0 SPI RAM frames for the fetch and load/store ports
module spi_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic [15:0] fetch_data,
  output logic        fetch_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_wdata,
  output logic [7:0]  data_rdata,
  output logic        data_ready,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DONE} state_t;
  state_t state;
  logic gnt_data, gnt_we;
  logic [38:0] sr;
  logic [15:0] rx;
  logic [5:0] cnt;
  logic [39:0] frame;
  logic [5:0] last;
  always_comb frame = data_req ? {data_we ? 8'h02 : 8'h03, data_addr, data_we ? data_wdata : 8'h00, 8'h00}
                               : {8'h03, fetch_addr, 16'h0000};
  assign last = gnt_data ? 6'd31 : 6'd39;
  // mosi and miso both move on the edge that ends each sck-high phase
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      spi_cs <= 1'b1;
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
      fetch_ready <= 1'b0;
      data_ready <= 1'b0;
      fetch_data <= '0;
      data_rdata <= '0;
      busy <= 1'b0;
      gnt_data <= 1'b0;
      gnt_we <= 1'b0;
      sr <= '0;
      rx <= '0;
      cnt <= '0;
    end else begin
      fetch_ready <= 1'b0;
      data_ready <= 1'b0;
      case (state)
        IDLE: if (data_req || fetch_req) begin
          state <= SELECT;
          gnt_data <= data_req;
          gnt_we <= data_req && data_we;
          sr <= frame[38:0];
          cnt <= '0;
          spi_cs <= 1'b0;
          spi_mosi <= frame[39];
          busy <= 1'b1;
        end
        SELECT: begin
          state <= SHIFT;
          spi_sck <= 1'b1;
        end
        SHIFT: if (spi_sck) begin
          spi_sck <= 1'b0;
          sr <= {sr[37:0], 1'b0};
          spi_mosi <= sr[38];
          rx <= {rx[14:0], spi_miso};
        end else if (cnt == last) begin
          state <= DONE;
          spi_cs <= 1'b1;
          spi_mosi <= 1'b0;
          fetch_ready <= !gnt_data;
          data_ready <= gnt_data;
          if (!gnt_data) fetch_data <= rx;
          if (gnt_data && !gnt_we) data_rdata <= rx[7:0];
        end else begin
          cnt <= cnt + 6'd1;
          spi_sck <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
